// File: rtl/spi_frame_decoder.sv
// spi_frame_decoder: assembles NUM_BYTES base-RADIX digit bytes per SPI frame into a binary value.
// Optional trailing XOR checksum byte when SPI_FRAME_CHECKSUM_EN is defined.
module spi_frame_decoder #(
    parameter int NUM_BYTES = 2,
    parameter int RADIX     = 100,
    parameter int OUT_W     = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       rx_data_i,
    input  logic             done_i,
    input  logic             ssn_i,
    output logic [OUT_W-1:0] data_o,
    output logic             data_valid_o,
    output logic             frame_err_o,
    output logic [2:0]       byte_cnt_o
);
    localparam int ACC_W = OUT_W + 7;
    localparam logic [ACC_W-1:0] MAX = ACC_W'((1 << OUT_W) - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    state_t             state_q, state_d;
    logic               done_q;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_n, fin_acc;
    logic [2:0]         cnt_q, cnt_d, cnt_n;
    logic               err_q, err_d, err_n;
    logic [7:0]         csum_q, csum_d, csum_n;
    logic [OUT_W-1:0]   data_q, data_d;
    logic               valid_q, valid_d, ferr_q, ferr_d;
    logic               ev, first, dig_err, fin, bad;
    logic [6:0]         digit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            csum_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_i;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            csum_q  <= csum_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        ev      = done_i & ~done_q & ~ssn_i;
        first   = state_q == IDLE;
        digit   = rx_data_i[6:0];
        dig_err = rx_data_i[7] | ({1'b0, digit} >= 8'(RADIX));
        // Once past MAX the frame is already lost; freezing acc avoids any wrap back into range.
        acc_n   = first ? ACC_W'(digit)
                : (acc_q > MAX ? acc_q : acc_q * ACC_W'(RADIX) + ACC_W'(digit));
        cnt_n   = first ? 3'd1 : cnt_q + 3'd1;
        err_n   = (first ? 1'b0 : err_q) | dig_err;
        csum_n  = (first ? 8'h00 : csum_q) ^ rx_data_i;
`ifdef SPI_FRAME_CHECKSUM_EN
        fin     = state_q == CHECK;
        fin_acc = acc_q;
        bad     = err_q | (acc_q > MAX) | (rx_data_i != csum_q);
`else
        fin     = cnt_n == 3'(NUM_BYTES);
        fin_acc = acc_n;
        bad     = err_n | (acc_n > MAX);
`endif
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        csum_d  = csum_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (!first && ssn_i) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            csum_d  = '0;
            ferr_d  = 1'b1;
        end else if (ev && fin) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            err_d   = 1'b0;
            csum_d  = '0;
            valid_d = ~bad;
            ferr_d  = bad;
            data_d  = bad ? data_q : fin_acc[OUT_W-1:0];
        end else if (ev) begin
            state_d = cnt_n == 3'(NUM_BYTES) ? CHECK : COLLECT;
            acc_d   = acc_n;
            cnt_d   = cnt_n;
            err_d   = err_n;
            csum_d  = csum_n;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
    assign byte_cnt_o   = cnt_q;
endmodule

// File: tb/tb_spi_frame_decoder.sv
// tb_spi_frame_decoder: directed table-driven check of spi_frame_decoder (2-byte and 3-byte instances).
module tb_spi_frame_decoder;
    logic        clk = 0, reset = 1, done = 0, ssn = 1, ssn1 = 1;
    logic [7:0]  rx = 0;
    logic [13:0] data0, data1;
    logic        v0, e0, v1, e1;
    logic [2:0]  cnt0, cnt1;
    int total = 0, bad = 0;
    int nv = 0, ne = 0, nboth = 0, nv1 = 0, ne1 = 0;

    spi_frame_decoder u0 (.clk(clk), .reset(reset), .rx_data_i(rx), .done_i(done), .ssn_i(ssn),
        .data_o(data0), .data_valid_o(v0), .frame_err_o(e0), .byte_cnt_o(cnt0));
    spi_frame_decoder #(.NUM_BYTES(3), .RADIX(100), .OUT_W(14)) u1 (.clk(clk), .reset(reset),
        .rx_data_i(rx), .done_i(done), .ssn_i(ssn1), .data_o(data1), .data_valid_o(v1),
        .frame_err_o(e1), .byte_cnt_o(cnt1));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        nv  += int'(v0);
        ne  += int'(e0);
        nv1 += int'(v1);
        ne1 += int'(e1);
        if (v0 && e0) nboth++;
    end

    typedef struct {
        logic [7:0] b0, b1;
        int         v;
        int         d;
    } vec_t;
    vec_t vt[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx = b;
        done = 1;
        repeat (hold) @(negedge clk);
        done = 0;
        @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input int hold);
        nv = 0;
        ne = 0;
        send_byte(b0, hold);
        send_byte(b1, hold);
`ifdef SPI_FRAME_CHECKSUM_EN
        send_byte(b0 ^ b1, hold);
`endif
        @(negedge clk);
    endtask

    task automatic send3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        nv1 = 0;
        ne1 = 0;
        send_byte(b0, 1);
        send_byte(b1, 1);
        send_byte(b2, 1);
`ifdef SPI_FRAME_CHECKSUM_EN
        send_byte(b0 ^ b1 ^ b2, 1);
`endif
        @(negedge clk);
    endtask

    initial begin
        vt[0] = '{8'h63, 8'h63, 1, 9999};
        vt[1] = '{8'h00, 8'h05, 1, 5};
        vt[2] = '{8'h0C, 8'h22, 1, 1234};
        vt[3] = '{8'h0C, 8'h64, 0, 1234};
        vt[4] = '{8'h8C, 8'h22, 0, 1234};
        vt[5] = '{8'h01, 8'h00, 1, 100};

        repeat (2) @(negedge clk);
        chk("reset_data", int'(data0), 0);
        chk("reset_valid", int'(v0), 0);
        chk("reset_err", int'(e0), 0);
        chk("reset_cnt", int'(cnt0), 0);
        reset = 0;
        ssn = 0;

        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].b0, vt[i].b1, 1);
            chk($sformatf("vec%0d_data", i), int'(data0), vt[i].d);
            chk($sformatf("vec%0d_valid", i), nv, vt[i].v);
            chk($sformatf("vec%0d_err", i), ne, 1 - vt[i].v);
            chk($sformatf("vec%0d_cnt", i), int'(cnt0), 0);
        end

        // latency: result visible at the negedge right after done is first sampled
        send_byte(8'h0C, 1);
        chk("lat_cnt1", int'(cnt0), 1);
        @(negedge clk);
        rx = 8'h22;
        done = 1;
`ifndef SPI_FRAME_CHECKSUM_EN
        @(negedge clk);
        chk("lat_valid", int'(v0), 1);
        chk("lat_data", int'(data0), 1234);
        done = 0;
        @(negedge clk);
        chk("lat_valid_1clk", int'(v0), 0);
`else
        @(negedge clk);
        chk("lat_cnt2", int'(cnt0), 2);
        done = 0;
        @(negedge clk);
        rx = 8'h2E;
        done = 1;
        @(negedge clk);
        chk("lat_valid", int'(v0), 1);
        chk("lat_data", int'(data0), 1234);
        done = 0;
        @(negedge clk);
        chk("lat_valid_1clk", int'(v0), 0);
`endif

        // abort by ssn between bytes
        send_byte(8'h05, 1);
        @(negedge clk);
        ssn = 1;
        @(negedge clk);
        chk("abort_err", int'(e0), 1);
        chk("abort_cnt", int'(cnt0), 0);
        @(negedge clk);
        chk("abort_err_1clk", int'(e0), 0);
        chk("abort_data", int'(data0), 1234);
        ssn = 0;
        send_frame(8'h00, 8'h07, 1);
        chk("after_abort_data", int'(data0), 7);
        chk("after_abort_valid", nv, 1);

        // ssn rising together with the final byte's done: abort wins
        send_byte(8'h0C, 1);
        @(negedge clk);
        rx = 8'h22;
        done = 1;
        ssn = 1;
        @(negedge clk);
        chk("simul_err", int'(e0), 1);
        chk("simul_valid", int'(v0), 0);
        done = 0;
        @(negedge clk);
        chk("simul_data", int'(data0), 7);
        ssn = 0;

        // done held for 5 clocks counts as one byte
        send_frame(8'h01, 8'h02, 5);
        chk("hold_data", int'(data0), 102);
        chk("hold_valid", nv, 1);
        chk("hold_err", ne, 0);

        // 3-byte instance range boundary
        ssn = 1;
        ssn1 = 0;
        send3(8'h02, 8'h00, 8'h00);
        chk("r3_over_err", ne1, 1);
        chk("r3_over_valid", nv1, 0);
        chk("r3_over_data", int'(data1), 0);
        send3(8'h01, 8'h3F, 8'h53);
        chk("r3_max_valid", nv1, 1);
        chk("r3_max_data", int'(data1), 16383);
        send3(8'h01, 8'h3F, 8'h54);
        chk("r3_max1_err", ne1, 1);
        chk("r3_max1_data", int'(data1), 16383);
        ssn1 = 1;
        ssn = 0;

`ifdef SPI_FRAME_CHECKSUM_EN
        nv = 0;
        ne = 0;
        send_byte(8'h0C, 1);
        send_byte(8'h22, 1);
        send_byte(8'h00, 1);
        @(negedge clk);
        chk("csum_bad_err", ne, 1);
        chk("csum_bad_data", int'(data0), 102);
`endif

        // reset mid-frame
        send_byte(8'h0C, 1);
        reset = 1;
        @(negedge clk);
        chk("midrst_data", int'(data0), 0);
        chk("midrst_cnt", int'(cnt0), 0);
        chk("midrst_valid", int'(v0), 0);
        chk("midrst_err", int'(e0), 0);
        reset = 0;
        send_frame(8'h00, 8'h09, 1);
        chk("post_rst_data", int'(data0), 9);
        chk("never_both", nboth, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
